cache_fill_fsm: RTL and testbench
=================================

// Module: cache_fill_fsm
// PURPOSE
//  Miss handler in front of the IF stage (I-cache) and the MEM stage (D-cache). On a cache miss it
//  fetches one 16-byte block (8 x 16-bit words) from the multi-cycle main memory, one word per
//  cycle, pipelined. It streams each returned word into the cache data array and writes the tag
//  with the last word. fsm_busy feeds the pipeline stall logic until the block is complete.
// PARAMETERS
//  DATA_W       16  word width, bits
//  ADDR_W       16  byte address width
//  BLOCK_WORDS  8   words per cache block (power of 2)
//  MEM_LAT      4   main memory request->data latency, cycles (bench model only; FSM is latency-agnostic)
// PORTS
//  clk                in   1       clock, rising edge
//  rst                in   1       synchronous, active-high reset
//  miss_detected      in   1       cache reports miss this cycle
//  miss_address       in   16      byte address that missed
//  fsm_busy           out  1       fill in progress; pipeline must stall
//  mem_req            out  1       memory read request valid this cycle
//  memory_address     out  16      word-aligned read address issued with mem_req
//  memory_data_valid  in   1       memory returns one word this cycle
//  memory_data        in   16      returned word
//  write_data_array   out  1       write fill_data into cache word fill_word_index
//  fill_word_index    out  3       word slot within block (0..7)
//  fill_data          out  16      word to write (= memory_data, combinational)
//  write_tag_array    out  1       write tag/valid for the block being filled
// BEHAVIOUR
//  States: IDLE, FILL. Registers: state, blk_base[15:0], issue_cnt[3:0], recv_cnt[2:0].
//  Reset: state=IDLE, counters=0, blk_base=0. All outputs 0 during reset and in IDLE with no miss.
//  IDLE: fsm_busy = miss_detected (combinational, so the stall asserts in the miss cycle).
//   miss_detected=1 -> latch blk_base = miss_address & 16'hFFF0; issue_cnt=0; recv_cnt=0; -> FILL.
//   memory_data_valid in IDLE is ignored (no array writes).
//  FILL: fsm_busy=1 on every cycle.
//   mem_req = (issue_cnt < 8); memory_address = blk_base + {issue_cnt[2:0],1'b0}. issue_cnt
//   increments while mem_req=1. Requests go out on 8 consecutive cycles, starting the first FILL cycle.
//   memory_data_valid=1 -> write_data_array=1, fill_word_index=recv_cnt, fill_data=memory_data, recv_cnt++.
//   Words are assumed to return in request order. Gaps in valid are allowed; no write on a gap.
//   Last word (recv_cnt==7 & valid): write_tag_array=1 in the same cycle; next state is IDLE.
//  Latency with MEM_LAT=4: miss in cycle 0 -> requests in cycles 1..8 -> data in 5..12.
//   Tag write is in cycle 12. fsm_busy is high in cycles 0..12 and low in cycle 13.
//  miss_detected during FILL: ignored; the fill in progress is never aborted. A new miss is
//   accepted once back in IDLE, including in the cycle right after the tag write.
//  Pipeline flush (branch) does not affect this block; the block always completes.
//  rst mid-fill: next cycle is IDLE with counters cleared. Late memory_data_valid is ignored.
//  blk_base + offset never carries past bit 3 (base aligned), so no wrap handling is needed.
//  Valid pulses beyond the 8th within one fill cannot occur; they are ignored (recv_cnt saturates via exit).
// STRUCTURE
//  cache_defs.vh: BLOCK_WORDS, BLOCK_OFFSET_MASK (16'hFFF0), state encodings IDLE=1'b0/FILL=1'b1.
//   Shared with the cache array and tag modules.
//  Sub-module fill_counter (parameterised width, sync clear, enable, increment), instantiated twice:
//   issue counter and receive counter.
//  State and blk_base are held in state_reg instances with synchronous reset.
// TESTING
//  1 Miss @0x1236, memory LAT=4 -> addrs 0x1230,0x1232..0x123E in cycles 1..8; 8 writes idx 0..7
//    in cycles 5..12; tag write in cycle 12; busy high in cycles 0..12.
//  2 Memory inserts a 2-cycle valid gap after word 3 -> no write during the gap; tag write is
//    delayed by 2; busy is extended by exactly 2 cycles.
//  3 miss_detected held high throughout the fill, addr changed to 0x4000 mid-fill -> still fills
//    0x1230 block; new fill of 0x4000 starts the cycle after the tag write.
//  4 rst asserted in cycle 6 of a fill -> cycle 7: busy=0, no array writes; stray valids ignored;
//    next miss 0x0008 fills 0x0000..0x000E from idx 0.
//  5 Back-to-back misses 0xFFF2 then 0x0010 -> first block is 0xFFF0..0xFFFE with no address
//    overflow; second block follows with correct indices.
//  6 memory_data_valid pulsed while IDLE -> write_data_array and write_tag_array stay 0.

Source files
------------

// File: rtl/cache_fill_fsm_pkg.sv
// ----------------------------------------------------------------------------
// cache_fill_fsm_pkg
//   Shared definitions for the cache miss/fill path: word and address widths,
//   block geometry, the block-offset mask and the fill FSM state encoding.
//   The cache data array and tag modules use the same constants.
// ----------------------------------------------------------------------------
package cache_fill_fsm_pkg;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 16;
    localparam int BLOCK_WORDS = 8;
    localparam int WORD_IDX_W  = $clog2(BLOCK_WORDS);

    // Clears the byte offset within a 16-byte block.
    localparam logic [ADDR_W-1:0] BLOCK_OFFSET_MASK = 16'hFFF0;

    // Issue counter runs one bit wider so it can reach BLOCK_WORDS and stop.
    localparam logic [WORD_IDX_W:0]   ISSUE_LIMIT = (WORD_IDX_W + 1)'(BLOCK_WORDS);
    localparam logic [WORD_IDX_W-1:0] LAST_WORD   = WORD_IDX_W'(BLOCK_WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// ----------------------------------------------------------------------------
// cache_fill_fsm_fill_counter
//   Small up-counter used for the request-issue and word-receive counts of a
//   block fill. Synchronous clear has priority over increment.
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   clr    in   synchronous clear to zero
//   en     in   increment by one
//   cnt_q  out  current count (W bits)
// ----------------------------------------------------------------------------
module cache_fill_fsm_fill_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt_q
);

    logic [W-1:0] cnt_d;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned; that is what keeps a latch from being inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // together on the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// ----------------------------------------------------------------------------
// cache_fill_fsm
//   Miss handler for the I-cache / D-cache. On a miss it reads one 8-word
//   block from main memory, issuing one pipelined request per cycle, streams
//   each returned word into the data array and writes the tag with the last
//   word. fsm_busy stalls the pipeline from the miss cycle until the tag write.
// Ports
//   clk, rst            clock; synchronous active-high reset
//   miss_detected       cache miss this cycle
//   miss_address[15:0]  byte address that missed
//   fsm_busy            fill in progress (combinational in the miss cycle)
//   mem_req             memory read request valid
//   memory_address      word-aligned read address issued with mem_req
//   memory_data_valid   memory returns one word this cycle
//   memory_data         returned word
//   write_data_array    write fill_data at fill_word_index
//   fill_word_index     word slot within the block
//   fill_data           word to write (memory_data while writing, else 0)
//   write_tag_array     write tag/valid for the block being filled
// ----------------------------------------------------------------------------
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_W-1:0]     miss_address,
    output logic                  fsm_busy,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     memory_address,
    input  logic                  memory_data_valid,
    input  logic [DATA_W-1:0]     memory_data,
    output logic                  write_data_array,
    output logic [WORD_IDX_W-1:0] fill_word_index,
    output logic [DATA_W-1:0]     fill_data,
    output logic                  write_tag_array
);

    fill_state_e             state_q, state_d;
    logic [ADDR_W-1:0]       blk_base_q, blk_base_d;
    logic [WORD_IDX_W:0]     issue_cnt_q;
    logic [WORD_IDX_W-1:0]   recv_cnt_q;
    logic                    cnt_clr;
    logic                    issue_en;
    logic                    recv_en;

    cache_fill_fsm_fill_counter #(.W(WORD_IDX_W + 1)) u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (issue_en),
        .cnt_q (issue_cnt_q)
    );

    cache_fill_fsm_fill_counter #(.W(WORD_IDX_W)) u_recv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (recv_en),
        .cnt_q (recv_cnt_q)
    );

    always_comb begin
        state_d          = state_q;
        blk_base_d       = blk_base_q;
        cnt_clr          = 1'b0;
        issue_en         = 1'b0;
        recv_en          = 1'b0;
        fsm_busy         = 1'b0;
        mem_req          = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_word_index  = '0;
        fill_data        = '0;
        write_tag_array  = 1'b0;

        // Reset silences every output in the same cycle, including a fill
        // that was in flight; the registers clear on the edge.
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    // Stall must assert in the miss cycle itself.
                    fsm_busy = miss_detected;
                    if (miss_detected) begin
                        blk_base_d = miss_address & BLOCK_OFFSET_MASK;
                        cnt_clr    = 1'b1;
                        state_d    = FILL;
                    end
                end

                FILL: begin
                    fsm_busy = 1'b1;
                    mem_req  = (issue_cnt_q < ISSUE_LIMIT);
                    issue_en = mem_req;
                    // Base is block aligned, so the word offset never carries.
                    memory_address = blk_base_q
                                   + {{(ADDR_W - WORD_IDX_W - 1){1'b0}},
                                      issue_cnt_q[WORD_IDX_W-1:0], 1'b0};
                    if (memory_data_valid) begin
                        write_data_array = 1'b1;
                        fill_word_index  = recv_cnt_q;
                        fill_data        = memory_data;
                        recv_en          = 1'b1;
                        if (recv_cnt_q == LAST_WORD) begin
                            write_tag_array = 1'b1;
                            state_d         = IDLE;
                        end
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: reset is synchronous here, so it is sampled only on the clock edge
    // and sits inside the edge-triggered block rather than in its sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            blk_base_q <= '0;
        end else begin
            state_q    <= state_d;
            blk_base_q <= blk_base_d;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// ----------------------------------------------------------------------------
// tb_cache_fill_fsm
//   Cycle-based bench with a pipelined main-memory model. Expected requests
//   and array writes are queued when a miss is accepted and are popped as the
//   DUT produces them. Memory returns addr ^ 16'h5A5A so a wrong request
//   address also shows up as wrong fill data.
// ----------------------------------------------------------------------------
module tb_cache_fill_fsm;

    localparam int MEM_LAT = 4;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
    } req_t;

    typedef struct {
        int          cyc;
        logic [2:0]  idx;
        logic [15:0] data;
        logic        last;
    } wr_t;

    typedef struct {
        int          due;
        logic [15:0] data;
    } pend_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        fsm_busy;
    logic        mem_req;
    logic [15:0] memory_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        write_data_array;
    logic [2:0]  fill_word_index;
    logic [15:0] fill_data;
    logic        write_tag_array;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .fsm_busy          (fsm_busy),
        .mem_req           (mem_req),
        .memory_address    (memory_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .write_data_array  (write_data_array),
        .fill_word_index   (fill_word_index),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    always #5 clk = ~clk;

    req_t  exp_req[$];
    wr_t   exp_wr[$];
    pend_t pend[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int m_until  = -1;   // cycle of the expected tag write of the current fill
    int req_idx  = 0;    // requests seen in the current fill
    int cur_gap  = 0;    // extra delay applied to words 4..7

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic accept_miss(input int c, input logic [15:0] a);
        logic [15:0] base;
        logic [15:0] wa;
        int          dl;
        base = a & 16'hFFF0;
        for (int i = 0; i < 8; i++) begin
            wa = base + 16'(2 * i);
            exp_req.push_back('{c + 1 + i, wa});
            dl = c + 1 + i + MEM_LAT + ((i >= 4) ? cur_gap : 0);
            exp_wr.push_back('{dl, 3'(i), mem_word(wa), (i == 7)});
        end
        m_until = c + 8 + MEM_LAT + cur_gap;
        req_idx = 0;
    endtask

    // One clock cycle: drive inputs, settle, compare, advance.
    task automatic run_cycle(input logic miss, input logic [15:0] addr,
                             input logic r, input logic inject);
        req_t rq;
        wr_t  wr;
        rst               = r;
        miss_detected     = miss;
        miss_address      = addr;
        memory_data_valid = 1'b0;
        memory_data       = 16'h0000;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            memory_data_valid = 1'b1;
            memory_data       = pend[0].data;
            void'(pend.pop_front());
        end
        if (inject) begin
            memory_data_valid = 1'b1;
            memory_data       = 16'hBEEF;
        end
        #1;
        if (r) begin
            exp_req.delete();
            exp_wr.delete();
            m_until = -1;
        end else if (miss && cyc > m_until) begin
            accept_miss(cyc, addr);
        end

        check("busy", 32'(fsm_busy), 32'(cyc <= m_until));

        if (mem_req) begin
            if (exp_req.size() == 0) begin
                check("unexpected_req", 32'(mem_req), 32'd0);
            end else begin
                rq = exp_req.pop_front();
                check("req_cycle", 32'(cyc), 32'(rq.cyc));
                check("req_addr", 32'(memory_address), 32'(rq.addr));
            end
            pend.push_back('{cyc + MEM_LAT + ((req_idx >= 4) ? cur_gap : 0),
                             mem_word(memory_address)});
            req_idx++;
        end else if (exp_req.size() > 0 && exp_req[0].cyc == cyc) begin
            check("missing_req", 32'(mem_req), 32'd1);
            void'(exp_req.pop_front());
        end

        if (write_data_array) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_write", 32'(write_data_array), 32'd0);
                check("unexpected_tag", 32'(write_tag_array), 32'd0);
            end else begin
                wr = exp_wr.pop_front();
                check("wr_cycle", 32'(cyc), 32'(wr.cyc));
                check("wr_idx", 32'(fill_word_index), 32'(wr.idx));
                check("wr_data", 32'(fill_data), 32'(wr.data));
                check("tag_write", 32'(write_tag_array), 32'(wr.last));
            end
        end else begin
            check("tag_without_write", 32'(write_tag_array), 32'd0);
            if (exp_wr.size() > 0 && exp_wr[0].cyc == cyc) begin
                check("missing_write", 32'(write_data_array), 32'd1);
                void'(exp_wr.pop_front());
            end
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic drained(input string tag);
        check({tag, "_req_q_empty"}, 32'(exp_req.size()), 32'd0);
        check({tag, "_wr_q_empty"}, 32'(exp_wr.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; miss_detected = 1'b0; miss_address = '0;
        memory_data_valid = 1'b0; memory_data = '0;
        @(negedge clk);

        // Reset state: all outputs low while reset is held.
        run_cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(fsm_busy), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(memory_address), 32'd0);
        check("rst_wr", 32'(write_data_array), 32'd0);
        check("rst_tag", 32'(write_tag_array), 32'd0);
        check("rst_data", 32'(fill_data), 32'd0);
        @(negedge clk);
        run_cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        idle(2);

        // 1: basic fill of block 0x1230, LAT=4.
        run_cycle(1'b1, 16'h1236, 1'b0, 1'b0);
        idle(16);
        drained("t1");

        // 2: two-cycle valid gap after word 3.
        cur_gap = 2;
        run_cycle(1'b1, 16'h1236, 1'b0, 1'b0);
        idle(18);
        drained("t2");
        cur_gap = 0;

        // 3: miss held through the fill, address changes mid-fill.
        for (int i = 0; i < 14; i++)
            run_cycle(1'b1, (i < 5) ? 16'h1236 : 16'h4000, 1'b0, 1'b0);
        idle(16);
        drained("t3");

        // 4: reset in cycle 6 of a fill; stray returns must be ignored.
        run_cycle(1'b1, 16'h1236, 1'b0, 1'b0);
        idle(5);
        run_cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        idle(8);
        check("t4_stray_done", 32'(pend.size()), 32'd0);
        run_cycle(1'b1, 16'h0008, 1'b0, 1'b0);
        idle(16);
        drained("t4");

        // 5: back-to-back misses at the top of the address space then 0x0010.
        run_cycle(1'b1, 16'hFFF2, 1'b0, 1'b0);
        idle(12);
        run_cycle(1'b1, 16'h0010, 1'b0, 1'b0);
        idle(16);
        drained("t5");

        // 6: valid pulses while idle never write the arrays.
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        run_cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        run_cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        idle(2);
        drained("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
